// File: rtl/aux_mix_sampler.sv
// rtl/aux_mix_sampler.sv - AUX_A/AUX_B channel mixer with box-car decimation and a single-entry PCM output register.
// Optional per-channel mute is enabled with the AUX_MUTE_EN macro.
module aux_mix_sampler #(
   parameter int LOG2_DECIM = 5,
   parameter int OUT_W      = 10
) (
   input  logic             CLK,
   input  logic             n_RES,
   input  logic [7:0]       AUX_A,
   input  logic [14:0]      AUX_B,
`ifdef AUX_MUTE_EN
   input  logic [4:0]       MUTE,
`endif
   input  logic             SAMPLE_EN,
   output logic [OUT_W-1:0] PCM,
   output logic             PCM_VALID,
   input  logic             PCM_READY,
   output logic             OVERRUN,
   input  logic             OVR_CLR
);

   localparam int AW    = 10 + LOG2_DECIM;
   localparam int CW    = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
   localparam int DECIM = 1 << LOG2_DECIM;

   logic [4:0]  mute;
`ifdef AUX_MUTE_EN
   assign mute = MUTE;
`else
   assign mute = 5'd0;
`endif

   logic [3:0]  sqa, sqb, tri_l, rnd;
   logic [6:0]  dmc;
   logic [9:0]  mix;

   assign sqa   = mute[0] ? 4'd0 : AUX_A[3:0];
   assign sqb   = mute[1] ? 4'd0 : AUX_A[7:4];
   assign tri_l = mute[2] ? 4'd0 : AUX_B[3:0];
   assign rnd   = mute[3] ? 4'd0 : AUX_B[7:4];
   assign dmc   = mute[4] ? 7'd0 : AUX_B[14:8];

   // Worst case is 831, so 10 bits never wrap.
   assign mix = (10'(sqa) + 10'(sqb)) * 10'd8 + 10'(tri_l) * 10'd9
              + 10'(rnd) * 10'd5 + 10'(dmc) * 10'd3;

   logic [9:0]    mix_r;
   logic          v1;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic [9:0]    avg_r;
   logic          done_r;
   logic [AW-1:0] sum;
   logic          last;

   assign last = (cnt == CW'(DECIM - 1));
   assign sum  = acc + AW'(mix_r);

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         mix_r <= '0;
         v1    <= 1'b0;
      end else begin
         v1 <= SAMPLE_EN;
         if (SAMPLE_EN)
            mix_r <= mix;
      end
   end

   // The completed average is registered once more so the output register
   // is written two edges after the edge that took the last sample.
   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         acc    <= '0;
         cnt    <= '0;
         avg_r  <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= v1 && last;
         if (v1) begin
            if (last) begin
               acc   <= '0;
               cnt   <= '0;
               avg_r <= sum[AW-1:LOG2_DECIM];
            end else begin
               acc <= sum;
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   logic [OUT_W-1:0] aligned;
   logic             consume, load, drop;

   assign aligned = OUT_W'(avg_r) << (OUT_W - 10);
   assign consume = PCM_VALID && PCM_READY;
   assign load    = done_r && (!PCM_VALID || consume);
   assign drop    = done_r && PCM_VALID && !PCM_READY;

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         PCM       <= '0;
         PCM_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (load) begin
            PCM       <= aligned;
            PCM_VALID <= 1'b1;
         end else if (consume) begin
            PCM_VALID <= 1'b0;
         end
         if (drop)
            OVERRUN <= 1'b1;
         else if (OVR_CLR)
            OVERRUN <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aux_mix_sampler.sv
// tb/tb_aux_mix_sampler.sv - self-checking bench for aux_mix_sampler with a window-level reference model.
module tb_aux_mix_sampler;

   localparam int LD    = 2;
   localparam int DECIM = 4;
   localparam int OW    = 10;

   logic          CLK = 1'b0;
   logic          n_RES = 1'b0;
   logic [7:0]    AUX_A = '0;
   logic [14:0]   AUX_B = '0;
   logic          SAMPLE_EN = 1'b0;
   logic          PCM_READY = 1'b0;
   logic          OVR_CLR = 1'b0;
   logic [OW-1:0] PCM;
   logic          PCM_VALID;
   logic          OVERRUN;
`ifdef AUX_MUTE_EN
   logic [4:0]    MUTE = '0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   aux_mix_sampler #(.LOG2_DECIM(LD), .OUT_W(OW)) dut (
      .CLK(CLK), .n_RES(n_RES), .AUX_A(AUX_A), .AUX_B(AUX_B),
`ifdef AUX_MUTE_EN
      .MUTE(MUTE),
`endif
      .SAMPLE_EN(SAMPLE_EN), .PCM(PCM), .PCM_VALID(PCM_VALID),
      .PCM_READY(PCM_READY), .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
   );

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: windows of accepted mixes, completions scheduled two edges out.
   int m_pcm = 0, m_valid = 0, m_ovr = 0, m_acc = 0, m_n = 0, cyc = 0;
   int due_q[$];
   int val_q[$];

   function automatic int mix_of(input logic [7:0] a, input logic [14:0] b, input logic [4:0] m);
      int sqa, sqb, tr, rn, dm;
      sqa = m[0] ? 0 : int'(a[3:0]);
      sqb = m[1] ? 0 : int'(a[7:4]);
      tr  = m[2] ? 0 : int'(b[3:0]);
      rn  = m[3] ? 0 : int'(b[7:4]);
      dm  = m[4] ? 0 : int'(b[14:8]);
      return 8 * (sqa + sqb) + 9 * tr + 5 * rn + 3 * dm;
   endfunction

   task automatic model_reset();
      m_pcm = 0; m_valid = 0; m_ovr = 0; m_acc = 0; m_n = 0;
      due_q.delete();
      val_q.delete();
   endtask

   task automatic model_step();
      int consume, done, drop, v;
      logic [4:0] mv;
`ifdef AUX_MUTE_EN
      mv = MUTE;
`else
      mv = 5'd0;
`endif
      cyc++;
      consume = (m_valid != 0) && PCM_READY;
      done = (due_q.size() > 0) && (due_q[0] == cyc);
      drop = 0;
      if (done) begin
         v = val_q.pop_front();
         void'(due_q.pop_front());
         if (!m_valid || consume) begin
            m_pcm = v;
            m_valid = 1;
         end else begin
            drop = 1;
         end
      end else if (consume) begin
         m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (OVR_CLR) m_ovr = 0;
      if (SAMPLE_EN) begin
         m_acc += mix_of(AUX_A, AUX_B, mv);
         m_n++;
         if (m_n == DECIM) begin
            due_q.push_back(cyc + 2);
            val_q.push_back((m_acc / DECIM) << (OW - 10));
            m_acc = 0;
            m_n = 0;
         end
      end
   endtask

   always @(posedge CLK or negedge n_RES) begin
      if (!n_RES) model_reset();
      else model_step();
   end

   always @(negedge CLK) begin
      check("valid", int'(PCM_VALID), m_valid);
      check("pcm", int'(PCM), m_pcm);
      check("overrun", int'(OVERRUN), m_ovr);
   end

   task automatic send(input logic [7:0] a, input logic [14:0] b);
      @(negedge CLK);
      AUX_A = a;
      AUX_B = b;
      SAMPLE_EN = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         SAMPLE_EN = 1'b0;
      end
   endtask

   // Watches six cycles after the last sample (PCM_READY expected high).
   task automatic collect(output int pulses, output int first_idx, output int val);
      pulses = 0; first_idx = -1; val = -1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         SAMPLE_EN = 1'b0;
         if (PCM_VALID) begin
            if (pulses == 0) begin
               first_idx = i;
               val = int'(PCM);
            end
            pulses++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int p, f, v;
      repeat (2) @(negedge CLK);
      check("rst_pcm", int'(PCM), 0);
      check("rst_valid", int'(PCM_VALID), 0);
      check("rst_ovr", int'(OVERRUN), 0);
      n_RES = 1'b1;
      PCM_READY = 1'b1;

      repeat (4) send(8'hFF, 15'h7FFF);
      collect(p, f, v);
      check("t1_pulses", p, 1);
      check("t1_latency", f, 2);
      check("t1_pcm", v, 831);
      check("t1_ovr", int'(OVERRUN), 0);

      for (int i = 0; i < 4; i++) send(8'(i), 15'd0);
      collect(p, f, v);
      check("t2_pcm", v, 12);

      @(negedge CLK);
      PCM_READY = 1'b0;
      repeat (4) send(8'h11, 15'd0);
      repeat (4) send(8'h22, 15'd0);
      idle(4);
      check("t3_valid", int'(PCM_VALID), 1);
      check("t3_pcm_held", int'(PCM), 16);
      check("t3_ovr", int'(OVERRUN), 1);
      repeat (4) send(8'h33, 15'd0);
      @(negedge CLK); SAMPLE_EN = 1'b0;
      @(negedge CLK); OVR_CLR = 1'b1;
      @(negedge CLK); OVR_CLR = 1'b0;
      check("t3_set_wins", int'(OVERRUN), 1);
      check("t3_pcm_still", int'(PCM), 16);
      @(negedge CLK); OVR_CLR = 1'b1;
      @(negedge CLK); OVR_CLR = 1'b0;
      check("t3_clr", int'(OVERRUN), 0);

      repeat (4) send(8'h44, 15'd0);
      @(negedge CLK); SAMPLE_EN = 1'b0;
      @(negedge CLK); PCM_READY = 1'b1;
      @(negedge CLK); PCM_READY = 1'b0;
      check("t4_valid", int'(PCM_VALID), 1);
      check("t4_pcm", int'(PCM), 64);
      check("t4_ovr", int'(OVERRUN), 0);
      @(negedge CLK); PCM_READY = 1'b1;
      idle(2);
      check("t4_drained", int'(PCM_VALID), 0);

      @(negedge CLK); PCM_READY = 1'b0;
      repeat (4) send(8'h00, 15'h0001);
      repeat (4) send(8'h00, 15'h0001);
      repeat (2) send(8'hFF, 15'd0);
      idle(2);
      check("t5_pre_valid", int'(PCM_VALID), 1);
      check("t5_pre_ovr", int'(OVERRUN), 1);
      #2 n_RES = 1'b0;
      #1;
      check("t5_async_pcm", int'(PCM), 0);
      check("t5_async_valid", int'(PCM_VALID), 0);
      check("t5_async_ovr", int'(OVERRUN), 0);
      @(negedge CLK);
      n_RES = 1'b1;
      PCM_READY = 1'b1;
      repeat (4) send(8'h30, 15'd0);
      collect(p, f, v);
      check("t5_post_pcm", v, 24);
      check("t5_post_pulses", p, 1);

`ifdef AUX_MUTE_EN
      @(negedge CLK); MUTE = 5'b00011;
      repeat (4) send(8'hFF, 15'd0);
      collect(p, f, v);
      check("t6_muted", v, 0);
      @(negedge CLK); MUTE = 5'b00000;
      repeat (4) send(8'hFF, 15'd0);
      collect(p, f, v);
      check("t6_unmuted", v, 240);
`endif

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aux_mix_sampler.md
Name: aux_mix_sampler

Overview:
- Receiving end of the DAC auxiliary buses AUX_A and AUX_B.
- Unpacks the per-channel digital levels, forms a weighted linear mix and decimates it by box-car averaging.
- Delivers one PCM sample per window over a valid/ready handshake.
- Sits between the APU DAC outputs and any downstream audio sink: I2S serializer, capture FIFO, or sim dump.

Parameters:
- LOG2_DECIM, 5, log2 of decimation ratio. DECIM = 2**LOG2_DECIM accepted input samples per output sample. Legal range 0..8.
- OUT_W, 10, PCM output width. Must be ≥10; the mix is zero-extended at the LSB end.

Ports:
- CLK  in  1  single system clock
- n_RES  in  1  asynchronous active-low reset
- AUX_A  in  8  {SQB[3:0], SQA[3:0]}
- AUX_B  in  15  {DMC[6:0], RND[3:0], TRI[3:0]}
- SAMPLE_EN  in  1  qualifier: sample AUX buses this CLK edge
- PCM  out  OUT_W  averaged mix sample
- PCM_VALID  out  1  PCM holds an unconsumed sample
- PCM_READY  in  1  sink accepts PCM when high with PCM_VALID
- OVERRUN  out  1  sticky: a completed sample was dropped
- OVR_CLR  in  1  synchronous clear of OVERRUN

Behaviour:
- Reset (n_RES low, async): all registers 0. This gives PCM=0, PCM_VALID=0, OVERRUN=0, window counter=0, accumulator=0, stage-1 regs=0.
- Unpack: SQA=AUX_A[3:0], SQB=AUX_A[7:4], TRI=AUX_B[3:0], RND=AUX_B[7:4], DMC=AUX_B[14:8].
- Mix (10-bit unsigned, combinational): MIX = 8*(SQA+SQB) + 9*TRI + 5*RND + 3*DMC. Maximum 240+135+75+381 = 831, so it never overflows 10 bits.
- Stage 1:
  - On an edge with SAMPLE_EN=1, MIX_R <= MIX and V1 <= 1.
  - Otherwise V1 <= 0.
  - AUX inputs are only looked at when SAMPLE_EN=1.
- Stage 2 (accumulator, width 10+LOG2_DECIM):
  - On an edge with V1=1 and CNT != DECIM-1: ACC <= ACC + MIX_R and CNT <= CNT+1.
  - On an edge with V1=1 and CNT == DECIM-1, the window completes:
    - AVG = (ACC + MIX_R) >> LOG2_DECIM, then left-aligned into OUT_W (MSBs = AVG, zero-padded LSBs).
    - ACC <= 0, CNT <= 0.
    - AVG goes to the output register per the rules below.
- Output register (single entry):
  - The sink consumes when PCM_VALID & PCM_READY on an edge.
  - Window complete and register empty, or consumed on the same edge: PCM <= AVG, PCM_VALID <= 1.
  - Window complete and register full and not consumed: AVG is discarded, PCM is unchanged, OVERRUN <= 1.
  - Consume with no completion: PCM_VALID <= 0. PCM keeps its last value.
  - PCM and PCM_VALID never change while PCM_VALID=1 and PCM_READY=0, except on reset.
- Latency: PCM_VALID rises 2 edges after the edge that samples the DECIM-th accepted SAMPLE_EN (edge k samples, edge k+2 presents). When LOG2_DECIM=0, every sample is output with the same 2-edge latency.
- OVERRUN:
  - Set wins over OVR_CLR on the same edge.
  - Otherwise OVR_CLR=1 clears it.
  - It is not cleared by consumption.
- SAMPLE_EN may be asserted on consecutive edges with no gaps; throughput is 1 sample/clock.
- Reset mid-window discards the partial accumulation and any pending output. There is no partial-window flush.

Optional Feature:
- Macro AUX_MUTE_EN.
- When defined: adds input port MUTE [4:0], with bit order {DMC, RND, TRI, SQB, SQA}. A set bit forces that channel's level to 0 before the mix. MUTE is sampled together with AUX on SAMPLE_EN edges, so a mute change takes effect from the next accepted sample.
- When undefined: the MUTE port does not exist and all channels always contribute.

Test Plan:
- Reset, then LOG2_DECIM=2, AUX_A=8'hFF, AUX_B=15'h7FFF, SAMPLE_EN high 4 edges, PCM_READY=1 -> exactly one PCM_VALID pulse 2 edges after the 4th sample; PCM[9:0]=831, OVERRUN=0.
- LOG2_DECIM=2, 4 samples with MIX = 0, 8, 16, 24 (SQA=0..3, others 0) -> PCM=12 (48>>2).
- PCM_READY=0, complete two windows -> first sample held stable with PCM_VALID=1; second dropped, OVERRUN=1. Then OVR_CLR=1 with a new completion on the same edge -> OVERRUN stays 1.
- PCM_READY toggled so consume and completion coincide -> new sample loaded with PCM_VALID continuously 1 and no OVERRUN.
- Assert n_RES low asynchronously mid-window (CNT=2) -> outputs immediately 0. After release, the next full window averages only post-reset samples.
- AUX_MUTE_EN defined, MUTE=5'b00011, AUX_A=8'hFF, AUX_B=0 -> PCM=0. With MUTE=0, the same inputs give PCM=240.
